// File: rtl/riscv_mt_pkg.sv
// Shared types and defaults for the multithreaded fetch front end.
package riscv_mt_pkg;

    typedef enum logic {
        READY   = 1'b0,
        BLOCKED = 1'b1
    } thread_state_t;

    localparam int PC_INC           = 4;
    localparam int DEFAULT_NTHREADS = 4;
    localparam int DEFAULT_TID_W    = $clog2(DEFAULT_NTHREADS);

endpackage

// File: rtl/branch_thread_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int TID_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [TID_W-1:0] last,
    output logic             gnt_valid,
    output logic [TID_W-1:0] gnt_id
);

    logic [TID_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        // N is a power of two, so the TID_W-bit add wraps modulo N; k == N revisits last itself.
        for (int k = 1; k <= N; k++) begin
            idx = last + TID_W'(k);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

endmodule

// File: rtl/branch_thread_scheduler.sv
// Round-robin fetch scheduler: one PC per thread, threads suspend on control flow until resolved.
module branch_thread_scheduler
    import riscv_mt_pkg::*;
#(
    parameter int          NTHREADS = DEFAULT_NTHREADS,
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int          TID_W    = $clog2(NTHREADS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NTHREADS-1:0] thread_en,
    input  logic                stall,
    input  logic                fetch_is_ctrl,
    output logic                fetch_valid,
    output logic [TID_W-1:0]    fetch_tid,
    output logic [XLEN-1:0]     fetch_pc,
    input  logic                ex_valid,
    input  logic [TID_W-1:0]    ex_tid,
    input  logic                ex_taken,
    input  logic [XLEN-1:0]     ex_target,
    output logic [NTHREADS-1:0] blocked,
    output logic                err
);

    thread_state_t       state_q [NTHREADS];
    logic [XLEN-1:0]     pc_q    [NTHREADS];
    logic [TID_W-1:0]    rr_last_q;
    logic [NTHREADS-1:0] req;
    logic                gnt_valid;
    logic [TID_W-1:0]    gnt_id;

    always_comb begin
        req     = '0;
        blocked = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            req[i]     = thread_en[i] && (state_q[i] == READY);
            blocked[i] = (state_q[i] == BLOCKED);
        end
    end

    rr_arbiter #(
        .N     (NTHREADS),
        .TID_W (TID_W)
    ) u_arb (
        .req       (req),
        .last      (rr_last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Outputs are forced to zero during reset so nothing downstream sees a stale grant.
    always_comb begin
        fetch_valid = gnt_valid && !reset;
        fetch_tid   = fetch_valid ? gnt_id : '0;
        fetch_pc    = fetch_valid ? pc_q[gnt_id] : '0;
    end

    // NOTE: state uses non-blocking assignments only, so every read here sees start-of-cycle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the PC array is architectural state and must come up at RESET_PC, so it is reset like any flop.
            for (int i = 0; i < NTHREADS; i++) begin
                pc_q[i]    <= RESET_PC;
                state_q[i] <= READY;
            end
            rr_last_q <= TID_W'(NTHREADS - 1);
            err       <= 1'b0;
        end else begin
            if (fetch_valid && !stall) begin
                pc_q[gnt_id] <= pc_q[gnt_id] + XLEN'(PC_INC);
                rr_last_q    <= gnt_id;
                if (fetch_is_ctrl) begin
                    state_q[gnt_id] <= BLOCKED;
                end
            end
            // A legal resolve always targets a BLOCKED thread, never the one granted this cycle.
            if (ex_valid) begin
                if (state_q[ex_tid] == BLOCKED) begin
                    state_q[ex_tid] <= READY;
                    if (ex_taken) begin
                        pc_q[ex_tid] <= ex_target;
                        if (ex_target[1:0] != 2'b00) begin
                            err <= 1'b1;
                        end
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_thread_scheduler.sv
// Directed plus randomized bench for branch_thread_scheduler against a behavioural thread model.
module tb_branch_thread_scheduler;

    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NT-1:0] thread_en;
    logic          stall;
    logic          fetch_is_ctrl;
    logic          fetch_valid;
    logic [1:0]    fetch_tid;
    logic [31:0]   fetch_pc;
    logic          ex_valid;
    logic [1:0]    ex_tid;
    logic          ex_taken;
    logic [31:0]   ex_target;
    logic [NT-1:0] blocked;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: per-thread pc and suspended flag, last winner, sticky error.
    logic [31:0]   m_pc [NT];
    logic [NT-1:0] m_blk;
    int            m_last;
    logic          m_err;

    branch_thread_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .thread_en     (thread_en),
        .stall         (stall),
        .fetch_is_ctrl (fetch_is_ctrl),
        .fetch_valid   (fetch_valid),
        .fetch_tid     (fetch_tid),
        .fetch_pc      (fetch_pc),
        .ex_valid      (ex_valid),
        .ex_tid        (ex_tid),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .blocked       (blocked),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_pc[i] = 32'h0;
        m_blk  = '0;
        m_last = NT - 1;
        m_err  = 1'b0;
    endtask

    // Scan the threads in rotation order starting just after the last winner.
    task automatic model_pick(output bit v, output int t);
        v = 0;
        t = 0;
        for (int k = 1; k <= NT; k++) begin
            int c;
            c = (m_last + k) % NT;
            if (!v && thread_en[c] && !m_blk[c]) begin
                v = 1;
                t = c;
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit            v;
        int            t;
        logic [NT-1:0] blk_old;
        #1;
        if (reset) begin
            v = 0;
            t = 0;
        end else begin
            model_pick(v, t);
        end
        check("fetch_valid", 32'(fetch_valid), 32'(v));
        check("fetch_tid", 32'(fetch_tid), v ? 32'(t) : 32'h0);
        check("fetch_pc", fetch_pc, v ? m_pc[t] : 32'h0);
        check("blocked", 32'(blocked), 32'(m_blk));
        check("err", 32'(err), 32'(m_err));
        if (reset) begin
            model_reset();
        end else begin
            blk_old = m_blk;
            if (v && !stall) begin
                m_pc[t] = m_pc[t] + 32'd4;
                m_last  = t;
                if (fetch_is_ctrl) m_blk[t] = 1'b1;
            end
            if (ex_valid) begin
                if (blk_old[ex_tid]) begin
                    m_blk[ex_tid] = 1'b0;
                    if (ex_taken) begin
                        m_pc[ex_tid] = ex_target;
                        if (ex_target[1:0] != 2'b00) m_err = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resolve(input int tid, input logic taken, input logic [31:0] target);
        ex_valid  = 1'b1;
        ex_tid    = 2'(tid);
        ex_taken  = taken;
        ex_target = target;
        cycle();
        ex_valid  = 1'b0;
        ex_taken  = 1'b0;
    endtask

    initial begin
        int seq2 [4] = '{2, 3, 0, 2};

        reset         = 1'b1;
        thread_en     = '1;
        stall         = 1'b0;
        fetch_is_ctrl = 1'b0;
        ex_valid      = 1'b0;
        ex_tid        = '0;
        ex_taken      = 1'b0;
        ex_target     = '0;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;

        // 1: plain rotation from reset, thread 0 first.
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t1_tid", 32'(fetch_tid), 32'(i % NT));
            check("t1_pc", fetch_pc, 32'((i / NT) * 4));
            cycle();
        end

        // 2: thread 1 suspends on a branch, rotation skips it, taken redirect to 0x100.
        fetch_is_ctrl = 1'b1;
        cycle();
        fetch_is_ctrl = 1'b0;
        #1;
        check("t2_blocked", 32'(blocked), 32'h2);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_rot", 32'(fetch_tid), 32'(seq2[i]));
            cycle();
        end
        resolve(1, 1'b1, 32'h100);
        cycle();
        #1;
        check("t2_redirect_tid", 32'(fetch_tid), 32'h1);
        check("t2_redirect_pc", fetch_pc, 32'h100);
        cycle();

        // 3: not-taken resolve resumes at the fall-through, then all threads blocked.
        fetch_is_ctrl = 1'b1;
        cycle();
        fetch_is_ctrl = 1'b0;
        resolve(2, 1'b0, 32'hdead_bee0);
        cycle();
        cycle();
        #1;
        check("t3_fallthru_tid", 32'(fetch_tid), 32'h2);
        check("t3_fallthru_pc", fetch_pc, 32'h10);
        fetch_is_ctrl = 1'b1;
        repeat (4) cycle();
        fetch_is_ctrl = 1'b0;
        #1;
        check("t3_all_blocked", 32'(blocked), 32'hf);
        check("t3_no_fetch", 32'(fetch_valid), 32'h0);
        cycle();
        cycle();
        for (int i = 0; i < NT; i++) resolve(i, 1'b0, 32'h0);

        // 4: stall for three cycles with thread 2 resolving mid-stall.
        thread_en     = 4'b0100;
        fetch_is_ctrl = 1'b1;
        cycle();
        fetch_is_ctrl = 1'b0;
        thread_en     = '1;
        stall         = 1'b1;
        cycle();
        resolve(2, 1'b1, 32'h200);
        cycle();
        stall = 1'b0;
        #1;
        check("t4_released", 32'(blocked), 32'h0);
        repeat (4) cycle();

        // 5: resolve aimed at a READY thread sets the sticky error.
        resolve(0, 1'b1, 32'h300);
        #1;
        check("t5_err_ready", 32'(err), 32'h1);
        repeat (3) cycle();

        // 6: reset while thread 0 waits on a branch with pc 0x40.
        thread_en     = 4'b0001;
        fetch_is_ctrl = 1'b1;
        cycle();
        resolve(0, 1'b1, 32'h3c);
        cycle();
        fetch_is_ctrl = 1'b0;
        #1;
        check("t6_pre_blocked", 32'(blocked), 32'h1);
        thread_en = '1;
        reset     = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("t6_blocked", 32'(blocked), 32'h0);
        check("t6_err", 32'(err), 32'h0);
        check("t6_tid", 32'(fetch_tid), 32'h0);
        check("t6_pc", fetch_pc, 32'h0);
        cycle();

        // 5b: misaligned taken target is still loaded but flags an error.
        fetch_is_ctrl = 1'b1;
        cycle();
        fetch_is_ctrl = 1'b0;
        resolve(1, 1'b1, 32'h102);
        #1;
        check("t5_err_misaligned", 32'(err), 32'h1);
        repeat (6) cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            thread_en     = 4'($urandom);
            if ($urandom_range(0, 3) != 0) thread_en = '1;
            stall         = ($urandom_range(0, 4) == 0);
            fetch_is_ctrl = ($urandom_range(0, 2) == 0);
            ex_valid      = ($urandom_range(0, 2) == 0);
            ex_tid        = 2'($urandom);
            ex_taken      = 1'($urandom);
            ex_target     = $urandom & (($urandom_range(0, 9) == 0) ? 32'hffff_ffff : 32'hffff_fffc);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
